// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start bit, 8 data + odd parity + stop, ACK, line idle.
// Optional macro PS2_TX_ACK_CHECK_EN: a high data line at the 11th clock fall is reported as an error.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, ready for a new byte
// INHIBIT   | clock held low for INHIBIT_CYCLES
// START     | clock still low, data low (start bit) for one cycle
// SEND      | clock released, next frame bit presented on each fall
// ACK       | stop bit released, waiting for the device's ACK fall
// WAIT_IDLE | waiting for both lines high before reporting done
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int TIMEOUT_CYCLES = 360000,
  parameter int FILTER_LEN     = 4
) (
  input  logic             clk_i,
  input  logic             res_n_i,
  ps2_host_tx_if.slave     bus,
  input  logic             ps2_clk_i,
  input  logic             ps2_dat_i,
  output logic             ps2_clk_oe_o,
  output logic             ps2_dat_oe_o
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [10:0]     shift, shift_nx;
  logic [3:0]      bit_cnt, bit_cnt_nx;
  logic            done_q, done_nx;
  logic            err_q, err_nx;

  // index 0 = clock line, index 1 = data line
  logic [1:0]      sync1, sync2, filt;
  logic [FW-1:0]   fcnt [2];
  logic            clk_filt_d;
  logic            fall;
  logic            timeout_hit;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      fcnt[0]    <= '0;
      fcnt[1]    <= '0;
      clk_filt_d <= 1'b1;
    end else begin
      sync1      <= {ps2_dat_i, ps2_clk_i};
      sync2      <= sync1;
      clk_filt_d <= filt[0];
      // a level is accepted only after FILTER_LEN consecutive differing samples
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_filt_d & ~filt[0];

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      shift   <= shift_nx;
      bit_cnt <= bit_cnt_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
    end
  end

  assign timeout_hit = ((state == SEND) || (state == ACK) || (state == WAIT_IDLE)) && (cnt == '0);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    done_nx    = 1'b0;
    err_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          // frame LSB first: start, data[7:0], odd parity, stop
          shift_nx   = {1'b1, ~^bus.tx_data, bus.tx_data, 1'b0};
          cnt_nx     = CW'(INHIBIT_CYCLES);
          bit_cnt_nx = '0;
          state_nx   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == '0) state_nx = START;
        else           cnt_nx   = cnt - 1'b1;
      end
      START: begin
        cnt_nx   = CW'(TIMEOUT_CYCLES);
        state_nx = SEND;
      end
      SEND: begin
        cnt_nx = cnt - 1'b1;
        if (fall) begin
          shift_nx   = {1'b1, shift[10:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 4'd9) state_nx = ACK;
        end
      end
      ACK: begin
        cnt_nx = cnt - 1'b1;
        if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          if (filt[1]) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_IDLE;
          end
`else
          state_nx = WAIT_IDLE;
`endif
        end
      end
      WAIT_IDLE: begin
        cnt_nx = cnt - 1'b1;
        if (filt == 2'b11) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (timeout_hit) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
      err_nx   = 1'b1;
    end
  end

  assign ps2_clk_oe_o = (state == INHIBIT) || (state == START);
  assign ps2_dat_oe_o = ((state == START) || (state == SEND)) && !shift[0];

  assign bus.tx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Drives ps2_host_tx against a behavioural PS/2 device model and checks frames, timing and pulses.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  logic clk;
  logic res_n;
  logic dev_clk, dev_dat;
  logic clk_oe, dat_oe;
  logic clk_line, dat_line;

  int n_asrt, n_fail;
  int done_cnt, err_cnt, both_cnt;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .clk_i        (clk),
    .res_n_i      (res_n),
    .bus          (bus),
    .ps2_clk_i    (clk_line),
    .ps2_dat_i    (dat_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe)
  );

  // open-drain wired-AND of host and device
  assign clk_line = ~clk_oe & dev_clk;
  assign dat_line = ~dat_oe & dev_dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err === 1'b1) err_cnt++;
    if (bus.done === 1'b1 && bus.err === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // nak: device leaves data high at fall 11; silent: device never clocks; rst_at: reset after that fall
  task automatic run_frame(input logic [7:0] b, input bit nak, input bit silent, input int rst_at);
    int n, d0, e0, exp_done, exp_err;
    logic [10:0] got;
    got = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    chk("accept_busy", {30'd0, bus.tx_ready, bus.busy}, 32'h1);

    n = 0;
    while (dat_oe !== 1'b1 && n < INH + 20) begin
      if (clk_oe === 1'b1) n++;
      @(negedge clk);
    end
    chk("inhibit_len", (n >= INH - 1 && n <= INH + 1) ? 32'd1 : 32'd0, 32'd1);
    chk("start_both_low", {30'd0, clk_oe, dat_oe}, 32'h3);
    @(negedge clk);
    chk("clk_released", {30'd0, clk_oe, dat_oe}, 32'h1);

    if (silent) begin
      n = 0;
      while (bus.err !== 1'b1 && n < TMO + 20) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_len", (n >= TMO - 1 && n <= TMO + 2) ? 32'd1 : 32'd0, 32'd1);
      chk("timeout_oe", {30'd0, clk_oe, dat_oe}, 32'h0);
      @(negedge clk);
      chk("timeout_ready", {31'd0, bus.tx_ready}, 32'h1);
      chk("timeout_no_done", done_cnt - d0, 32'd0);
      return;
    end

    got[0] = dat_line;
    for (int k = 1; k <= 11; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (k == rst_at) begin
        repeat (HALF / 2) @(negedge clk);
        #3 res_n = 1'b0;
        #1;
        chk("rst_outputs", {26'd0, clk_oe, dat_oe, bus.tx_ready, bus.busy, bus.done, bus.err}, 32'h08);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (5) @(negedge clk);
        res_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        return;
      end
      repeat (HALF) @(negedge clk);
      if (k <= 10) got[k] = dat_line;
      dev_clk = 1'b1;
      if (k == 10) dev_dat = nak;
    end
    repeat (HALF) @(negedge clk);
    dev_dat = 1'b1;

    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);

    exp_done = 1;
    exp_err  = 0;
`ifdef PS2_TX_ACK_CHECK_EN
    if (nak) begin
      exp_done = 0;
      exp_err  = 1;
    end
`endif
    chk($sformatf("frame_bits_%02h", b), {21'd0, got}, {21'd0, ref_frame(b)});
    chk($sformatf("done_count_%02h", b), done_cnt - d0, exp_done);
    chk($sformatf("err_count_%02h", b), err_cnt - e0, exp_err);
    chk("idle_after", {28'd0, bus.tx_ready, bus.busy, clk_oe, dat_oe}, 32'h8);
  endtask

  initial begin
    n_asrt = 0; n_fail = 0;
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    res_n = 1'b0;
    repeat (5) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", {31'd0, bus.tx_ready}, 32'h1);
    chk("rst_busy", {31'd0, bus.busy}, 32'h0);
    chk("rst_pulses", {30'd0, bus.done, bus.err}, 32'h0);
    chk("rst_oe", {30'd0, clk_oe, dat_oe}, 32'h0);

    run_frame(8'hED, 1'b0, 1'b0, 0);
    run_frame(8'h01, 1'b0, 1'b0, 0);
    run_frame(8'hFF, 1'b0, 1'b0, 0);
    run_frame(8'h00, 1'b0, 1'b0, 0);
    for (int r = 0; r < 4; r++) run_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
    run_frame(8'hA5, 1'b1, 1'b0, 0);
    run_frame(8'h3C, 1'b0, 1'b1, 0);
    run_frame(8'h77, 1'b0, 1'b0, 5);
    run_frame(8'hF4, 1'b0, 1'b0, 0);

    chk("never_done_and_err", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
